// File: rtl/usb_cmd_deframer.sv
// rtl/usb_cmd_deframer.sv - EZ-USB slave-FIFO command packet deframer (optional CHECKSUM_EN trailer check)
module usb_cmd_deframer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         LEN_W     = 11,
    parameter int         MAX_LEN   = 1024
) (
    input  logic             ifclk,
    input  logic             reset_n,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [15:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_first,
    output logic             out_last,
    output logic [7:0]       out_cmd,
    output logic [LEN_W-1:0] out_len,
    output logic             pkt_done,
    output logic             pkt_err,
    output logic [7:0]       err_count,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CSUM    = 3'd3,
        S_DROP    = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] count;
    logic             accept;
    logic             is_sync;
    logic             len_bad;
    logic             last_word;
    logic             done_evt;
    logic             err_evt;
`ifdef CHECKSUM_EN
    logic [15:0]      sum;
`endif

    // Only the payload state can stall; everything else swallows words unconditionally.
    assign in_ready  = (state == S_PAYLOAD) ? (!out_valid || out_ready) : 1'b1;
    assign accept    = in_valid && in_ready;
    assign is_sync   = (in_data[15:8] == SYNC_BYTE);
    assign len_bad   = (in_data[LEN_W-1:0] == '0) || (in_data[LEN_W-1:0] > MAX_LEN_V) ||
                       (in_data[15:LEN_W] != '0);
    assign last_word = (count == out_len - 1'b1);
    assign state_dbg = state;

    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_evt  = 1'b0;
        err_evt   = 1'b0;
        case (state)
            S_HUNT, S_DROP: begin
                if (accept && is_sync) begin
                    state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (len_bad) begin
                        err_evt   = 1'b1;
                        state_nxt = S_HUNT;
                    end else begin
                        state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept && last_word) begin
`ifdef CHECKSUM_EN
                    state_nxt = S_CSUM;
`else
                    done_evt  = 1'b1;
                    state_nxt = S_HUNT;
`endif
                end
            end
            S_CSUM: begin
`ifdef CHECKSUM_EN
                if (accept) begin
                    done_evt  = (in_data == sum);
                    err_evt   = (in_data != sum);
                    state_nxt = S_HUNT;
                end
`else
                state_nxt = S_HUNT;
`endif
            end
            default: state_nxt = S_HUNT;
        endcase
    end

    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_cmd   <= '0;
            out_len   <= '0;
            count     <= '0;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;
            err_count <= '0;
`ifdef CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            pkt_done <= done_evt;
            pkt_err  <= err_evt;
            if (err_evt && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end

            if (state == S_PAYLOAD && accept) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
                out_first <= (count == '0);
                out_last  <= last_word;
                count     <= count + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if ((state == S_HUNT || state == S_DROP) && accept && is_sync) begin
                out_cmd <= in_data[7:0];
            end
            if (state == S_LEN && accept && !len_bad) begin
                out_len <= in_data[LEN_W-1:0];
                count   <= '0;
            end

`ifdef CHECKSUM_EN
            // Running sum covers header, length and payload; the checksum word itself is excluded.
            if ((state == S_HUNT || state == S_DROP) && accept && is_sync) begin
                sum <= in_data;
            end else if ((state == S_LEN || state == S_PAYLOAD) && accept) begin
                sum <= sum + in_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_usb_cmd_deframer.sv
// tb/tb_usb_cmd_deframer.sv - randomized scoreboard bench for usb_cmd_deframer
module tb_usb_cmd_deframer;

    logic        ifclk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_first;
    logic        out_last;
    logic [7:0]  out_cmd;
    logic [10:0] out_len;
    logic        pkt_done;
    logic        pkt_err;
    logic [7:0]  err_count;
    logic [2:0]  state_dbg;

    usb_cmd_deframer dut (
        .ifclk(ifclk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_first(out_first), .out_last(out_last),
        .out_cmd(out_cmd), .out_len(out_len),
        .pkt_done(pkt_done), .pkt_err(pkt_err),
        .err_count(err_count), .state_dbg(state_dbg)
    );

    always #5 ifclk = ~ifclk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state that persists across streams (cleared by reset)
    logic [7:0]  m_cmd = '0;
    logic [10:0] m_len = '0;
    int          m_err = 0;
    logic [17:0] exp_out[$];
    int          exp_evt[$];
    logic [15:0] stim[$];

    function automatic void model_err();
        exp_evt.push_back(2);
        if (m_err < 255) m_err++;
    endfunction

    // Walk the word stream as a packet parser: skip non-sync words, validate length, emit payload.
    function automatic void model();
        int i = 0;
        int n = stim.size();
        logic [15:0] sum;
        logic [15:0] len;
        while (i < n) begin
            if (stim[i][15:8] != 8'hA5) begin
                i++;
                continue;
            end
            m_cmd = stim[i][7:0];
            sum = stim[i];
            i++;
            if (i >= n) break;
            len = stim[i];
            i++;
            if (len == 0 || len > 1024) begin
                model_err();
                continue;
            end
            m_len = len[10:0];
            sum = sum + len;
            for (int k = 0; k < int'(len); k++) begin
                if (i >= n) break;
                exp_out.push_back({1'(k == 0), 1'(k == int'(len) - 1), stim[i]});
                sum = sum + stim[i];
                i++;
            end
`ifdef CHECKSUM_EN
            if (i < n) begin
                if (stim[i] == sum) exp_evt.push_back(1);
                else model_err();
                i++;
            end
`else
            exp_evt.push_back(1);
`endif
        end
    endfunction

    function automatic void push_pkt(input logic [7:0] cmd, input logic [15:0] len, input bit corrupt);
        logic [15:0] sum;
        logic [15:0] w;
        stim.push_back({8'hA5, cmd});
        stim.push_back(len);
        sum = {8'hA5, cmd} + len;
        if (len == 0 || len > 1024) return;
        for (int k = 0; k < int'(len); k++) begin
            w = 16'($urandom);
            stim.push_back(w);
            sum = sum + w;
        end
`ifdef CHECKSUM_EN
        stim.push_back(corrupt ? (sum ^ 16'h0101) : sum);
`else
        if (corrupt) sum = '0;
`endif
    endfunction

    task automatic gen_random(input int npk);
        logic [15:0] w;
        int r;
        for (int p = 0; p < npk; p++) begin
            for (int g = 0; g < int'($urandom_range(2)); g++) begin
                w = 16'($urandom);
                if (w[15:8] == 8'hA5) w[15:8] = 8'h5A;
                stim.push_back(w);
            end
            r = int'($urandom_range(9));
            if (r == 0)      push_pkt(8'($urandom), 16'h0000, 1'b0);
            else if (r == 1) push_pkt(8'($urandom), 16'(1025 + $urandom_range(20)), 1'b0);
            else if (r == 2) push_pkt(8'($urandom), 16'h0800 | 16'($urandom_range(8)), 1'b0);
            else             push_pkt(8'($urandom), 16'($urandom_range(8, 1)), $urandom_range(3) == 0);
        end
    endtask

    task automatic run_stream(input string name, input int rdy_pct, input int vld_pct);
        logic [17:0] got_out[$];
        int got_evt[$];
        int idx = 0;
        int drain = 0;
        int n = stim.size();
        int limit = n * 30 + 100;
        int m;
        exp_out.delete();
        exp_evt.delete();
        model();
        for (int c = 0; c < limit && drain < 12; c++) begin
            @(negedge ifclk);
            if (pkt_done || pkt_err) chk({name, "_excl"}, {31'd0, pkt_done & pkt_err}, 32'd0);
            if (pkt_done) got_evt.push_back(1);
            if (pkt_err)  got_evt.push_back(2);
            if (idx >= n) drain++;
            out_ready = (idx >= n) ? 1'b1 : ($urandom_range(99) < rdy_pct);
            in_valid  = (idx < n) && ($urandom_range(99) < vld_pct);
            in_data   = (idx < n && in_valid) ? stim[idx] : 16'($urandom);
            #1;
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) got_out.push_back({out_first, out_last, out_data});
        end
        in_valid = 1'b0;
        chk({name, "_consumed"}, idx, n);
        chk({name, "_nwords"}, got_out.size(), exp_out.size());
        m = (got_out.size() < exp_out.size()) ? got_out.size() : exp_out.size();
        for (int k = 0; k < m; k++) chk($sformatf("%s_word%0d", name, k), {14'd0, got_out[k]}, {14'd0, exp_out[k]});
        chk({name, "_nevt"}, got_evt.size(), exp_evt.size());
        m = (got_evt.size() < exp_evt.size()) ? got_evt.size() : exp_evt.size();
        for (int k = 0; k < m; k++) chk($sformatf("%s_evt%0d", name, k), got_evt[k], exp_evt[k]);
        chk({name, "_errcnt"}, {24'd0, err_count}, m_err);
        chk({name, "_cmd"}, {24'd0, out_cmd}, {24'd0, m_cmd});
        chk({name, "_len"}, {21'd0, out_len}, {21'd0, m_len});
        chk({name, "_state"}, {29'd0, state_dbg}, 32'd0);
        chk({name, "_ovalid"}, {31'd0, out_valid}, 32'd0);
        stim.delete();
    endtask

    task automatic check_reset_values(input string name);
        chk({name, "_ovalid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_first"}, {31'd0, out_first}, 32'd0);
        chk({name, "_last"}, {31'd0, out_last}, 32'd0);
        chk({name, "_data"}, {16'd0, out_data}, 32'd0);
        chk({name, "_cmd"}, {24'd0, out_cmd}, 32'd0);
        chk({name, "_len"}, {21'd0, out_len}, 32'd0);
        chk({name, "_done"}, {31'd0, pkt_done}, 32'd0);
        chk({name, "_err"}, {31'd0, pkt_err}, 32'd0);
        chk({name, "_errcnt"}, {24'd0, err_count}, 32'd0);
        chk({name, "_state"}, {29'd0, state_dbg}, 32'd0);
        chk({name, "_inrdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int idx;
        repeat (3) @(negedge ifclk);
        check_reset_values("rst");
        reset_n = 1'b1;

        stim = {16'hA503, 16'h0002, 16'h1111, 16'h2222};
`ifdef CHECKSUM_EN
        stim.push_back(16'hD838);
`endif
        run_stream("clean", 100, 100);

        stim = {16'hA503, 16'h0002, 16'h1111, 16'h2222};
`ifdef CHECKSUM_EN
        stim.push_back(16'hD838);
`endif
        run_stream("bpress", 25, 100);

        stim = {16'h1234, 16'h00A5, 16'hA507, 16'h0001, 16'hBEEF};
`ifdef CHECKSUM_EN
        stim.push_back(16'h63F7);
`endif
        run_stream("garbage", 100, 100);

        stim = {16'hA501, 16'h0000, 16'hA501, 16'h0401};
        run_stream("badlen", 100, 100);

        stim = {16'hA503, 16'h0002, 16'h1111, 16'h2222, 16'h0000};
        run_stream("badsum", 100, 100);

        push_pkt(8'h11, 16'd1024, 1'b0);
        push_pkt(8'h12, 16'd1025, 1'b0);
        push_pkt(8'h13, 16'd1, 1'b0);
        run_stream("maxlen", 100, 100);

        gen_random(20);
        run_stream("rand_full", 100, 100);
        gen_random(20);
        run_stream("rand_bp", 40, 70);
        gen_random(20);
        run_stream("rand_slow", 80, 30);

        for (int p = 0; p < 260; p++) push_pkt(8'($urandom), 16'h0000, 1'b0);
        run_stream("satur", 100, 100);

        // Abort a packet after its first payload word has been presented.
        stim = {16'hA503, 16'h0002, 16'h1111};
        idx = 0;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            @(negedge ifclk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_data   = stim[idx];
            #1;
            if (in_ready) idx++;
        end
        @(negedge ifclk);
        in_valid = 1'b0;
        chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("mid_pre_data", {16'd0, out_data}, 32'h1111);
        stim.delete();
        reset_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        m_cmd = '0;
        m_len = '0;
        m_err = 0;
        repeat (2) @(negedge ifclk);
        reset_n = 1'b1;
        stim = {16'hA503, 16'h0002, 16'h1111, 16'h2222};
`ifdef CHECKSUM_EN
        stim.push_back(16'hD838);
`endif
        run_stream("post_rst", 100, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
